dat_read_multi: RTL and testbench

- Receive side of the SD DAT bus, successor to the single-block 4-bit reader.
- Supports runtime-selectable bus width (1, 4 or 8 lines) and multi-block transfers with one start command.
- Deserialises each block into little-endian 32-bit words and checks per-line CRC16 and end bit per block.
- Sits between the SD pad interface and the data FIFO/DMA; crc16_read is instantiated once per line.

---
 rtl/dat_read_multi.sv | 188 ++++++++++++++++++
 tb/tb_dat_read_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_read_multi.sv
// rtl/dat_read_multi.sv - SD DAT receive path: 1/4/8 lines, multi-block, per-line CRC16; optional DAT_READ_TIMEOUT_EN start-bit timeout

module crc16_read (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic fb;
  assign fb = din ^ crc[15];

  // Serial CRC16-CCITT (x^16+x^12+x^5+1); reads zero after a block followed by its own CRC.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) crc <= '0;
    else if (en)       crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end
endmodule

module dat_read_multi #(
  parameter int MaxBlockBitSize = 12,
  parameter int BlockCountWidth = 16,
  parameter int TimeoutCycles   = 1024
) (
  input  logic                       sd_clk_i,
  input  logic                       rst_ni,
  input  logic [7:0]                 dat_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [1:0]                 bus_width_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  output logic                       data_valid_o,
  output logic [31:0]                data_o,
  output logic                       block_done_o,
  output logic                       done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       timeout_o
);
  localparam int CW = MaxBlockBitSize + 3;

  typedef enum logic [2:0] {IDLE, WAIT_START, DAT, CRC, END_BIT} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 mode_q;      // 0: 1 line, 1: 4 lines, 2: 8 lines
  logic [MaxBlockBitSize-1:0] size_q;
  logic [BlockCountWidth-1:0] remaining_q;
  logic [CW-1:0]              cnt_q, last_cnt;
  logic [7:0]                 shift_q, byte_next, mask, crc_nz;
  logic [31:0]                word_q;
  logic [1:0]                 slot;
  logic                       byte_done, start_bit, timed_out;
  logic [15:0]                crc [8];

  // Per-width byte assembly: next byte value, byte completion and byte slot within the word.
  always_comb begin
    mask      = 8'hFF;
    byte_next = dat_i;
    byte_done = 1'b1;
    slot      = cnt_q[1:0];
    last_cnt  = CW'(size_q) - CW'(1);
    case (mode_q)
      2'd0: begin
        mask      = 8'h01;
        byte_next = {shift_q[6:0], dat_i[0]};
        byte_done = &cnt_q[2:0];
        slot      = cnt_q[4:3];
        last_cnt  = {size_q, 3'b000} - CW'(1);
      end
      2'd1: begin
        mask      = 8'h0F;
        byte_next = {shift_q[3:0], dat_i[3:0]};
        byte_done = cnt_q[0];
        slot      = cnt_q[2:1];
        last_cnt  = {2'b00, size_q, 1'b0} - CW'(1);
      end
      default: ;
    endcase
  end

  assign start_bit = ((dat_i & mask) == 8'h00);

`ifdef DAT_READ_TIMEOUT_EN
  assign timed_out = (state_q == WAIT_START) && (cnt_q == CW'(TimeoutCycles));
`else
  localparam int unused_timeout_cycles = TimeoutCycles;
  assign timed_out = 1'b0;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_crc
    crc16_read u_crc (
      .clk   (sd_clk_i),
      .rst_n (rst_ni),
      .clr   (state_q == WAIT_START),
      .en    ((state_q == DAT) || (state_q == CRC)),
      .din   (dat_i[i]),
      .crc   (crc[i])
    );
    assign crc_nz[i] = |crc[i];
  end

  // State register.
  always_ff @(posedge sd_clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_i) state_d = WAIT_START;
      WAIT_START: if (timed_out) state_d = IDLE;
                  else if (start_bit) state_d = DAT;
      DAT:        if (cnt_q == last_cnt) state_d = CRC;
      CRC:        if (cnt_q[3:0] == 4'hF) state_d = END_BIT;
      END_BIT:    state_d = (remaining_q == BlockCountWidth'(1)) ? IDLE : WAIT_START;
      default:    state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  // Datapath: transfer parameters, phase counter (restarts on every state change), byte/word buffers.
  always_ff @(posedge sd_clk_i) begin
    if (!rst_ni) begin
      mode_q      <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      word_q      <= '0;
    end else begin
      if (state_q == IDLE || state_d != state_q) cnt_q <= '0;
      else                                        cnt_q <= cnt_q + CW'(1);
      case (state_q)
        IDLE: if (start_i) begin
          mode_q      <= (bus_width_i == 2'd3) ? 2'd0 : bus_width_i;
          size_q      <= block_size_i;
          remaining_q <= (block_count_i == '0) ? BlockCountWidth'(1) : block_count_i;
        end
        WAIT_START: word_q <= '0;
        DAT: begin
          shift_q <= byte_next;
          if (byte_done) begin
            if (slot == 2'd3) word_q <= '0;
            else              word_q[8*slot +: 8] <= byte_next;
          end
        end
        END_BIT: remaining_q <= remaining_q - BlockCountWidth'(1);
        default: ;
      endcase
    end
  end

  // Outputs: words complete combinationally on their last bit; partial word in first CRC cycle.
  always_comb begin
    data_valid_o  = 1'b0;
    data_o        = '0;
    block_done_o  = 1'b0;
    done_o        = 1'b0;
    crc_err_o     = 1'b0;
    end_bit_err_o = 1'b0;
    timeout_o     = 1'b0;
    case (state_q)
      WAIT_START: if (timed_out && !abort_i) begin
        done_o    = 1'b1;
        timeout_o = 1'b1;
      end
      DAT: if (byte_done && slot == 2'd3) begin
        data_valid_o = 1'b1;
        data_o       = {byte_next, word_q[23:0]};
      end
      CRC: if (cnt_q == '0 && size_q[1:0] != 2'b00) begin
        data_valid_o = 1'b1;
        data_o       = word_q;
      end
      END_BIT: begin
        block_done_o  = 1'b1;
        crc_err_o     = |(crc_nz & mask);
        end_bit_err_o = |(~dat_i & mask);
        done_o        = (remaining_q == BlockCountWidth'(1)) && !abort_i;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dat_read_multi.sv
// tb/tb_dat_read_multi.sv - scoreboard bench for dat_read_multi with a bit-level bus model

module tb_dat_read_multi;
  localparam int MBS = 12;
  localparam int BCW = 16;

  typedef logic [7:0] bq_t[$];

  logic           sd_clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [7:0]     dat_i = 8'hFF;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [1:0]     bus_width_i = 2'd0;
  logic [MBS-1:0] block_size_i = '0;
  logic [BCW-1:0] block_count_i = '0;
  logic           data_valid_o;
  logic [31:0]    data_o;
  logic           block_done_o, done_o, crc_err_o, end_bit_err_o, timeout_o;

  int checks = 0;
  int passes = 0;
  int seen;
  int tw, tsz, tcnt, tln, tnb;

  logic [31:0] exp_words[$];
  logic [2:0]  exp_blk[$];   // {crc_err, end_bit_err, done}

  always #5 sd_clk_i = ~sd_clk_i;

  dat_read_multi #(
    .MaxBlockBitSize (MBS),
    .BlockCountWidth (BCW),
    .TimeoutCycles   (16)
  ) dut (
    .sd_clk_i      (sd_clk_i),
    .rst_ni        (rst_ni),
    .dat_i         (dat_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .bus_width_i   (bus_width_i),
    .block_size_i  (block_size_i),
    .block_count_i (block_count_i),
    .data_valid_o  (data_valid_o),
    .data_o        (data_o),
    .block_done_o  (block_done_o),
    .done_o        (done_o),
    .crc_err_o     (crc_err_o),
    .end_bit_err_o (end_bit_err_o),
    .timeout_o     (timeout_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // CRC16-CCITT as polynomial long division of M(x)*x^16 by G(x), MSB first
  function automatic logic [15:0] crc_ref(input bit bits[$]);
    logic [16:0] g;
    bit          r[$];
    logic [15:0] res;
    g = 17'h11021;
    r = bits;
    for (int k = 0; k < 16; k++) r.push_back(1'b0);
    for (int i = 0; i < bits.size(); i++)
      if (r[i]) for (int k = 0; k <= 16; k++) r[i+k] = r[i+k] ^ g[16-k];
    for (int k = 0; k < 16; k++) res[15-k] = r[bits.size()+k];
    return res;
  endfunction

  function automatic bq_t make_bytes(input int n, input bit seq);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(seq ? 8'(i + 1) : 8'($urandom));
    return q;
  endfunction

  function automatic logic [7:0] lane_mask(input int lines);
    return (lines == 1) ? 8'h01 : (lines == 4) ? 8'h0F : 8'hFF;
  endfunction

  task automatic drive(input logic [7:0] v);
    dat_i = v;
    @(posedge sd_clk_i);
    #1;
  endtask

  task automatic start(input logic [1:0] w, input int size, input int count);
    bus_width_i   = w;
    block_size_i  = MBS'(size);
    block_count_i = BCW'(count);
    start_i = 1'b1;
    drive(8'hFF);
    start_i = 1'b0;
  endtask

  task automatic run_block(input int lines, input bq_t bytes, input int bad_line,
                           input logic [7:0] end_bad, input int idle, input bit last);
    logic [7:0]  m, v;
    logic [7:0]  cyc[$];
    bit          lb[$];
    logic [15:0] crc[8];
    logic [31:0] word;
    m = lane_mask(lines);
    foreach (bytes[n]) begin
      if (lines == 8) cyc.push_back(bytes[n]);
      else if (lines == 4) begin
        cyc.push_back({4'h0, bytes[n][7:4]});
        cyc.push_back({4'h0, bytes[n][3:0]});
      end else for (int k = 7; k >= 0; k--) cyc.push_back({7'h0, bytes[n][k]});
    end
    for (int i = 0; i < 8; i++) crc[i] = '0;
    for (int i = 0; i < lines; i++) begin
      lb.delete();
      foreach (cyc[c]) lb.push_back(cyc[c][i]);
      crc[i] = crc_ref(lb);
    end
    if (bad_line >= 0) crc[bad_line][3] = ~crc[bad_line][3];
    for (int w = 0; w * 4 < bytes.size(); w++) begin
      word = '0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < bytes.size()) word = word | (32'(bytes[w*4+k]) << (8 * k));
      exp_words.push_back(word);
    end
    exp_blk.push_back({bad_line >= 0, (end_bad & m) != 8'h00, last});
    repeat (idle) drive(m | (8'($urandom) & ~m));
    drive(8'($urandom) & ~m);
    foreach (cyc[c]) drive((cyc[c] & m) | (8'($urandom) & ~m));
    for (int k = 0; k < 16; k++) begin
      v = '0;
      for (int i = 0; i < lines; i++) v[i] = crc[i][15-k];
      drive(v | (8'($urandom) & ~m));
    end
    drive((m & ~end_bad) | (8'($urandom) & ~m));
  endtask

  task automatic partial_block(input int lines, input int ncyc);
    logic [7:0] m;
    m = lane_mask(lines);
    drive(m | (8'($urandom) & ~m));
    drive(8'($urandom) & ~m);
    repeat (ncyc) drive(8'($urandom));
  endtask

  task automatic transfer(input logic [1:0] w, input int size, input int count, input int bad_blk,
                          input int bad_line, input int eb_blk, input logic [7:0] eb, input bit seq);
    int lines, nb;
    lines = (w == 2'd1) ? 4 : (w == 2'd2) ? 8 : 1;
    nb = (count == 0) ? 1 : count;
    start(w, size, count);
    for (int b = 0; b < nb; b++)
      run_block(lines, make_bytes(size, seq), (b == bad_blk) ? bad_line : -1,
                (b == eb_blk) ? eb : 8'h00, int'($urandom_range(0, 3)), b == nb - 1);
    drive(8'hFF);
    drive(8'hFF);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge sd_clk_i);
    check({tag, "_valid"}, 32'(data_valid_o), 32'd0);
    check({tag, "_data"}, data_o, 32'd0);
    check({tag, "_block_done"}, 32'(block_done_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_errs"}, 32'({crc_err_o, end_bit_err_o, timeout_o}), 32'd0);
    @(posedge sd_clk_i);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word or a block status
  always @(negedge sd_clk_i) begin
    if (rst_ni) begin
      if (data_valid_o) begin
        if (exp_words.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: data_o=%h with no word expected", data_o);
        end else check("data_o", data_o, exp_words.pop_front());
      end
      if (block_done_o) begin
        if (exp_blk.size() == 0) begin
          checks++;
          $display("FAIL unexpected_block_done: status=%b with no block expected",
                   {crc_err_o, end_bit_err_o, done_o});
        end else check("block_status", 32'({crc_err_o, end_bit_err_o, done_o}), 32'(exp_blk.pop_front()));
      end
`ifndef DAT_READ_TIMEOUT_EN
      if ((done_o || timeout_o) && !block_done_o) begin
        checks++;
        $display("FAIL stray_done: done_o=%b timeout_o=%b without block_done_o, expected 0", done_o, timeout_o);
      end
`endif
    end
  end

  initial begin
    #1;
    repeat (3) drive(8'hFF);
    check_quiet("reset");
    rst_ni = 1'b1;
    drive(8'hFF);

    transfer(2'd1, 512, 1, -1, 0, -1, 8'h00, 1'b0);
    transfer(2'd0, 6, 1, -1, 0, -1, 8'h00, 1'b1);
    transfer(2'd2, 8, 3, 1, 5, -1, 8'h00, 1'b0);
    transfer(2'd1, 8, 2, -1, 0, 0, 8'h04, 1'b0);

    start(2'd1, 16, 4);
    run_block(4, make_bytes(16, 1'b0), -1, 8'h00, 1, 1'b0);
    partial_block(4, 3);
    abort_i = 1'b1;
    drive(8'($urandom));
    abort_i = 1'b0;
    check_quiet("abort");
    repeat (20) drive(8'($urandom));
    transfer(2'd1, 12, 1, -1, 0, -1, 8'h00, 1'b0);

    start(2'd2, 8, 2);
    partial_block(8, 2);
    rst_ni = 1'b0;
    drive(8'($urandom));
    check_quiet("mid_reset");
    rst_ni = 1'b1;
    drive(8'hFF);
    transfer(2'd3, 5, 0, -1, 0, -1, 8'h00, 1'b0);

    for (int t = 0; t < 8; t++) begin
      tw   = int'($urandom_range(0, 3));
      tsz  = int'($urandom_range(1, 20));
      tcnt = int'($urandom_range(0, 3));
      tln  = (tw == 1) ? 4 : (tw == 2) ? 8 : 1;
      tnb  = (tcnt == 0) ? 1 : tcnt;
      transfer(2'(tw), tsz, tcnt, int'($urandom_range(0, tnb)), int'($urandom_range(0, tln - 1)),
               int'($urandom_range(0, tnb)), 8'($urandom), 1'b0);
    end

`ifdef DAT_READ_TIMEOUT_EN
    start(2'd1, 4, 1);
    seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      @(negedge sd_clk_i);
      if (done_o && timeout_o) seen = i;
      @(posedge sd_clk_i);
      #1;
    end
    check("timeout_cycle", 32'(seen), 32'd16);
`endif

    repeat (5) drive(8'hFF);
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("blocks_left", 32'(exp_blk.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
